display_list_reader: RTL and testbench

Port-A reader for the shared 32-bit display RAM that the port-B writer fills. On each frame start it walks the RAM from address 0 and unpacks each 32-bit entry into code, color, row and column fields. It hands the fields to the downstream renderer over a valid/ready handshake and stops at a terminator entry or at the last address. Sits between the dual-port RAM (port A) and the VGA character/sprite renderer.

---
 rtl/display_list_reader_if.sv | 42 ++++
 rtl/display_list_reader.sv | 107 ++++++++++
 tb/tb_display_list_reader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_list_reader_if.sv
// Bundles the port-A RAM signals, the frame trigger and the entry
// handshake toward the renderer. The master modport is the list reader.
interface display_list_reader_if;
    // RAM port A
    logic [11:0] addr_a;
    logic [31:0] data_a;
    logic        we_a;
    logic [31:0] q_a;

    // Frame trigger and status
    logic        frame_start;
    logic        busy;
    logic        done;

    // Entry handshake toward the renderer
    logic        ent_valid;
    logic        ent_ready;
    logic [7:0]  ent_code;
    logic [5:0]  ent_color;
    logic [7:0]  ent_row;
    logic [9:0]  ent_col;

    modport master (
        output addr_a, data_a, we_a,
        input  q_a,
        input  frame_start,
        output busy, done,
        output ent_valid,
        input  ent_ready,
        output ent_code, ent_color, ent_row, ent_col
    );

    modport slave (
        input  addr_a, data_a, we_a,
        output q_a,
        output frame_start,
        input  busy, done,
        input  ent_valid,
        output ent_ready,
        input  ent_code, ent_color, ent_row, ent_col
    );
endinterface

// File: rtl/display_list_reader.sv
// Display list reader: on each frame start, walks the display RAM through
// port A from address 0. Each 32-bit word is unpacked into code/color/row/col
// and offered to the renderer over valid/ready. The walk stops at a
// terminator code or after LAST_ADDR has been handed over.
module display_list_reader #(
    parameter logic [11:0] LAST_ADDR = 12'd4095,
    parameter logic [7:0]  TERM_CODE = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    display_list_reader_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        OUT
    } state_t;

    state_t      state;
    logic [11:0] rd_addr;
    logic [11:0] addr_reg;
    logic        valid_reg;
    logic        done_reg;
    logic [7:0]  code_reg;
    logic [5:0]  color_reg;
    logic [7:0]  row_reg;
    logic [9:0]  col_reg;

    // Port A is only ever read, so the write side is tied off.
    assign bus.data_a    = 32'h0000_0000;
    assign bus.we_a      = 1'b0;
    assign bus.addr_a    = addr_reg;
    assign bus.ent_valid = valid_reg;
    assign bus.done      = done_reg;
    assign bus.ent_code  = code_reg;
    assign bus.ent_color = color_reg;
    assign bus.ent_row   = row_reg;
    assign bus.ent_col   = col_reg;
    assign bus.busy      = (state != IDLE);

    // Walk FSM: frame_start restarts from any state, otherwise ADDR -> DATA -> OUT per entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= 12'd0;
            addr_reg  <= 12'd0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            code_reg  <= 8'd0;
            color_reg <= 6'd0;
            row_reg   <= 8'd0;
            col_reg   <= 10'd0;
        end else begin
            done_reg <= 1'b0;
            if (bus.frame_start) begin
                // A restart drops any offered entry; if it was also accepted
                // this cycle, the renderer keeps it and it is not re-offered.
                state     <= ADDR;
                rd_addr   <= 12'd0;
                addr_reg  <= 12'd0;
                valid_reg <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ADDR: begin
                        state <= DATA;
                    end
                    DATA: begin
                        code_reg  <= bus.q_a[31:24];
                        color_reg <= bus.q_a[23:18];
                        row_reg   <= bus.q_a[17:10];
                        col_reg   <= bus.q_a[9:0];
                        if (bus.q_a[31:24] == TERM_CODE) begin
                            done_reg <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            valid_reg <= 1'b1;
                            state     <= OUT;
                        end
                    end
                    OUT: begin
                        if (bus.ent_ready) begin
                            valid_reg <= 1'b0;
                            if (rd_addr == LAST_ADDR) begin
                                done_reg <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                rd_addr  <= rd_addr + 12'd1;
                                addr_reg <= rd_addr + 12'd1;
                                state    <= ADDR;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_list_reader.sv
// Testbench for display_list_reader: a synchronous RAM model feeds port A,
// and accepted entries are compared with the list predicted from RAM contents.
module tb_display_list_reader;

    localparam logic [11:0] LAST = 12'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_list_reader_if bus();

    display_list_reader #(
        .LAST_ADDR (LAST),
        .TERM_CODE (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];

    // Synchronous read port, one cycle of latency
    always @(posedge clk) bus.q_a <= mem[bus.addr_a];

    logic [31:0] cur_fields;
    assign cur_fields = {bus.ent_code, bus.ent_color, bus.ent_row, bus.ent_col};

    int asserts = 0;
    int failures = 0;

    logic [31:0] acc[$];
    logic [31:0] expq[$];
    int valid_rises[$];
    int done_cycles[$];
    int stall_bad, overlap, busy_bad, max_addr, timeout, restart_cycle, stall_left;

    // Reference: the list is every word from address 0 up to the terminator or LAST
    task automatic build_expected();
        expq.delete();
        for (int a = 0; a <= int'(LAST); a++) begin
            if (mem[a][31:24] == 8'h00) break;
            expq.push_back(mem[a]);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 16; a++) mem[a] = 32'h0;
    endtask

    task automatic load_short_list();
        clear_mem();
        mem[0] = {8'd68, 6'b111010, 8'd69, 10'h290};
        mem[1] = {8'd5, 6'b000011, 8'd12, 10'h015};
        mem[2] = {8'd6, 6'b110000, 8'd200, 10'h3FF};
        mem[3] = {8'd0, 6'b101010, 8'd77, 10'h123};
        mem[4] = {8'd9, 6'b010101, 8'd1, 10'h001};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame walk and records what the renderer side observes.
    // mode 0: ready high, 1: 4-cycle stall on entry 1, 2: random ready, 3: restart in OUT of entry 1
    task automatic walk(input int mode, input int max_cycles);
        int cyc;
        logic last_valid;
        logic prev_stall;
        logic [31:0] prev_fields;
        bit restarted;
        acc.delete();
        valid_rises.delete();
        done_cycles.delete();
        stall_bad = 0; overlap = 0; busy_bad = 0; max_addr = 0; timeout = 0;
        restart_cycle = -1; stall_left = 4;
        cyc = 0; last_valid = 1'b0; restarted = 1'b0;
        bus.frame_start = 1'b1;
        forever begin
            case (mode)
                1: begin
                    if (bus.ent_valid && acc.size() == 1 && stall_left > 0) begin
                        bus.ent_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.ent_ready = 1'b1;
                    end
                end
                2: bus.ent_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    bus.ent_ready = 1'b1;
                    if (!restarted && bus.ent_valid && acc.size() == 1) begin
                        bus.frame_start = 1'b1;
                        restarted = 1'b1;
                        restart_cycle = cyc;
                    end
                end
                default: bus.ent_ready = 1'b1;
            endcase
            if (bus.ent_valid && bus.ent_ready) acc.push_back(cur_fields);
            prev_stall = bus.ent_valid && !bus.ent_ready;
            prev_fields = cur_fields;
            step();
            cyc++;
            bus.frame_start = 1'b0;
            if (prev_stall && (!bus.ent_valid || cur_fields != prev_fields)) stall_bad++;
            if (bus.ent_valid && !last_valid) valid_rises.push_back(cyc);
            last_valid = bus.ent_valid;
            if (bus.done) begin
                done_cycles.push_back(cyc);
                if (bus.busy) busy_bad++;
                if (bus.ent_valid) overlap++;
            end
            if (int'(bus.addr_a) > max_addr) max_addr = int'(bus.addr_a);
            if (done_cycles.size() > 0 && cyc >= done_cycles[0] + 3) break;
            if (cyc >= max_cycles) begin
                timeout = 1;
                break;
            end
        end
        bus.ent_ready = 1'b0;
    endtask

    task automatic test_reset();
        int idle_bad;
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.ent_ready = 1'b0;
        step();
        step();
        asserts++;
        if ({bus.addr_a, bus.ent_valid, bus.busy, bus.done, bus.we_a} !== 16'h0 ||
            bus.data_a !== 32'h0 || cur_fields !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_values: addr_a=%0d valid=%b busy=%b done=%b we_a=%b data_a=%h fields=%h, required all 0",
                     bus.addr_a, bus.ent_valid, bus.busy, bus.done, bus.we_a, bus.data_a, cur_fields);
        end
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.busy || bus.ent_valid || bus.done) idle_bad++;
        end
        asserts++;
        if (idle_bad !== 0) begin
            failures++;
            $display("[TB] FAIL idle_without_frame_start: %0d active cycles, required 0", idle_bad);
        end
        // Stall an entry, then reset between clock edges
        load_short_list();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2 rst = 1'b1;
        #1;
        asserts++;
        if (bus.ent_valid !== 1'b0 || bus.busy !== 1'b0 || bus.addr_a !== 12'd0 || cur_fields !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: valid=%b busy=%b addr_a=%0d fields=%h, required 0/0/0/0",
                     bus.ent_valid, bus.busy, bus.addr_a, cur_fields);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_short_list();
        load_short_list();
        build_expected();
        walk(0, 100);
        asserts++;
        if (timeout !== 0 || acc.size() !== expq.size()) begin
            failures++;
            $display("[TB] FAIL short_count: timeout=%0d entries=%0d, required 0/%0d", timeout, acc.size(), expq.size());
        end
        for (int i = 0; i < acc.size() && i < expq.size(); i++) begin
            asserts++;
            if (acc[i] !== expq[i]) begin
                failures++;
                $display("[TB] FAIL short_entry%0d: got %h, required %h", i, acc[i], expq[i]);
            end
        end
        asserts++;
        if (acc.size() < 1 || acc[0][31:24] !== 8'd68 || acc[0][23:18] !== 6'b111010 ||
            acc[0][17:10] !== 8'd69 || acc[0][9:0] !== 10'h290) begin
            failures++;
            $display("[TB] FAIL short_first_fields: got %h, required %h", (acc.size() > 0) ? acc[0] : 32'h0,
                     {8'd68, 6'b111010, 8'd69, 10'h290});
        end
        asserts++;
        if (valid_rises.size() !== 3 || valid_rises[0] !== 3 || valid_rises[1] !== 6 || valid_rises[2] !== 9) begin
            failures++;
            $display("[TB] FAIL short_timing: %0d presentations, first three at %0d %0d %0d, required 3 at 3 6 9",
                     valid_rises.size(), (valid_rises.size() > 0) ? valid_rises[0] : -1,
                     (valid_rises.size() > 1) ? valid_rises[1] : -1, (valid_rises.size() > 2) ? valid_rises[2] : -1);
        end
        asserts++;
        if (done_cycles.size() !== 1 || busy_bad !== 0 || overlap !== 0) begin
            failures++;
            $display("[TB] FAIL short_done: pulses=%0d busy_with_done=%0d valid_with_done=%0d, required 1/0/0",
                     done_cycles.size(), busy_bad, overlap);
        end
        asserts++;
        if (max_addr !== 3) begin
            failures++;
            $display("[TB] FAIL short_max_addr: got %0d, required 3", max_addr);
        end
    endtask

    task automatic test_backpressure();
        load_short_list();
        build_expected();
        walk(1, 100);
        asserts++;
        if (timeout !== 0 || acc.size() !== expq.size()) begin
            failures++;
            $display("[TB] FAIL bp_count: timeout=%0d entries=%0d, required 0/%0d", timeout, acc.size(), expq.size());
        end
        for (int i = 0; i < acc.size() && i < expq.size(); i++) begin
            asserts++;
            if (acc[i] !== expq[i]) begin
                failures++;
                $display("[TB] FAIL bp_entry%0d: got %h, required %h", i, acc[i], expq[i]);
            end
        end
        asserts++;
        if (stall_bad !== 0) begin
            failures++;
            $display("[TB] FAIL bp_stable: %0d stall cycles changed fields or dropped valid, required 0", stall_bad);
        end
        asserts++;
        if (valid_rises.size() < 3 || valid_rises[2] !== 13) begin
            failures++;
            $display("[TB] FAIL bp_latency: third presentation at %0d, required 13",
                     (valid_rises.size() > 2) ? valid_rises[2] : -1);
        end
    endtask

    task automatic test_full_sweep();
        clear_mem();
        for (int a = 0; a <= int'(LAST); a++)
            mem[a] = {8'(a + 16), 6'(a * 5), 8'(a * 3 + 1), 10'(a * 37)};
        mem[8] = {8'd99, 24'hABCDEF};
        build_expected();
        walk(0, 100);
        asserts++;
        if (timeout !== 0 || acc.size() !== 8) begin
            failures++;
            $display("[TB] FAIL sweep_count: timeout=%0d entries=%0d, required 0/8", timeout, acc.size());
        end
        for (int i = 0; i < acc.size() && i < expq.size(); i++) begin
            asserts++;
            if (acc[i] !== expq[i]) begin
                failures++;
                $display("[TB] FAIL sweep_entry%0d: got %h, required %h", i, acc[i], expq[i]);
            end
        end
        asserts++;
        if (max_addr !== 7 || bus.addr_a !== 12'd7) begin
            failures++;
            $display("[TB] FAIL sweep_addr: max=%0d final=%0d, required 7/7", max_addr, bus.addr_a);
        end
        asserts++;
        if (done_cycles.size() !== 1 || busy_bad !== 0 || overlap !== 0) begin
            failures++;
            $display("[TB] FAIL sweep_done: pulses=%0d busy_with_done=%0d valid_with_done=%0d, required 1/0/0",
                     done_cycles.size(), busy_bad, overlap);
        end
    endtask

    task automatic test_restart();
        logic [31:0] rexp[$];
        load_short_list();
        build_expected();
        rexp.delete();
        rexp.push_back(expq[0]);
        rexp.push_back(expq[1]);
        foreach (expq[i]) rexp.push_back(expq[i]);
        walk(3, 100);
        asserts++;
        if (timeout !== 0 || acc.size() !== rexp.size()) begin
            failures++;
            $display("[TB] FAIL restart_count: timeout=%0d entries=%0d, required 0/%0d", timeout, acc.size(), rexp.size());
        end
        for (int i = 0; i < acc.size() && i < rexp.size(); i++) begin
            asserts++;
            if (acc[i] !== rexp[i]) begin
                failures++;
                $display("[TB] FAIL restart_entry%0d: got %h, required %h", i, acc[i], rexp[i]);
            end
        end
        asserts++;
        if (done_cycles.size() !== 1) begin
            failures++;
            $display("[TB] FAIL restart_done: pulses=%0d, required 1", done_cycles.size());
        end
        asserts++;
        if (valid_rises.size() < 3 || valid_rises[2] !== restart_cycle + 3) begin
            failures++;
            $display("[TB] FAIL restart_latency: presentation at %0d, required %0d",
                     (valid_rises.size() > 2) ? valid_rises[2] : -1, restart_cycle + 3);
        end
    endtask

    task automatic test_mid_walk_reset();
        int idle_bad;
        load_short_list();
        build_expected();
        bus.ent_ready = 1'b1;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        asserts++;
        if (bus.ent_valid !== 1'b0 || bus.busy !== 1'b0 || cur_fields !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midwalk_reset: valid=%b busy=%b fields=%h, required 0/0/0",
                     bus.ent_valid, bus.busy, cur_fields);
        end
        step();
        rst = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.busy || bus.ent_valid || bus.done) idle_bad++;
        end
        asserts++;
        if (idle_bad !== 0) begin
            failures++;
            $display("[TB] FAIL midwalk_idle: %0d active cycles, required 0", idle_bad);
        end
        walk(0, 100);
        asserts++;
        if (acc.size() < 1 || acc[0] !== mem[0] || valid_rises.size() < 1 || valid_rises[0] !== 3) begin
            failures++;
            $display("[TB] FAIL midwalk_fresh: first=%h at %0d, required %h at 3",
                     (acc.size() > 0) ? acc[0] : 32'h0, (valid_rises.size() > 0) ? valid_rises[0] : -1, mem[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            clear_mem();
            for (int a = 0; a <= int'(LAST); a++) begin
                mem[a] = $urandom;
                if (mem[a][31:24] == 8'h00) mem[a][31:24] = 8'h01;
                if ($urandom_range(0, 5) == 0) mem[a][31:24] = 8'h00;
            end
            build_expected();
            walk(2, 400);
            asserts++;
            if (timeout !== 0 || acc.size() !== expq.size()) begin
                failures++;
                $display("[TB] FAIL rand%0d_count: timeout=%0d entries=%0d, required 0/%0d",
                         it, timeout, acc.size(), expq.size());
            end
            for (int i = 0; i < acc.size() && i < expq.size(); i++) begin
                asserts++;
                if (acc[i] !== expq[i]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_entry%0d: got %h, required %h", it, i, acc[i], expq[i]);
                end
            end
            asserts++;
            if (stall_bad !== 0 || overlap !== 0 || busy_bad !== 0 || done_cycles.size() !== 1) begin
                failures++;
                $display("[TB] FAIL rand%0d_protocol: stall_bad=%0d overlap=%0d busy_bad=%0d done_pulses=%0d, required 0/0/0/1",
                         it, stall_bad, overlap, busy_bad, done_cycles.size());
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        bus.frame_start = 1'b0;
        bus.ent_ready = 1'b0;
        test_reset();
        test_short_list();
        test_backpressure();
        test_full_sweep();
        test_restart();
        test_mid_walk_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
